// File: rtl/nice_icb_mem_if.sv
// ICB command/response bus between the NICE accelerator (master) and its
// memory (slave).
interface nice_icb_mem_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );
endinterface

// File: rtl/nice_icb_mem.sv
// ICB slave memory for the NICE memory port. Commands act on a word-addressed
// array when accepted; responses return in order after LATENCY cycles through
// a credit-limited response FIFO.
module nice_icb_mem #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  nice_icb_mem_if.slave  bus,
  output logic [4:0]     outstanding
);

  // Elaboration-time parameter checks
  if (ADDR_BASE[1:0] != 2'b00) begin : g_chk_base
    $error("nice_icb_mem: ADDR_BASE must be 4-byte aligned");
  end
  if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH > (1 << 30)) begin : g_chk_depth
    $error("nice_icb_mem: DEPTH must be a power of 2");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_chk_lat
    $error("nice_icb_mem: LATENCY must be in 1..8");
  end
  if (RSP_DEPTH < 1 || RSP_DEPTH > 16) begin : g_chk_rsp
    $error("nice_icb_mem: RSP_DEPTH must be in 1..16");
  end

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

  logic [31:0]   r_mem [DEPTH];
  logic [4:0]    r_out;

  logic          w_acc;
  logic          w_legal;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_acc_err;
  logic [31:0]   w_acc_rdata;

  logic          w_push_v;
  logic          w_push_err;
  logic [31:0]   w_push_rdata;

  logic          r_f_err   [RSP_DEPTH];
  logic [31:0]   r_f_rdata [RSP_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [4:0]    r_cnt;
  logic          w_fifo_ne;
  logic          w_pop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Command decode: address range/alignment check and read data capture
  always_comb begin
    w_off       = bus.icb_cmd_addr - ADDR_BASE;
    w_idx       = w_off[AW+1:2];
    w_legal     = (bus.icb_cmd_addr[1:0] == 2'b00) && ({1'b0, w_off} < LIMIT);
    w_acc       = bus.icb_cmd_valid && bus.icb_cmd_ready;
    w_acc_err   = !w_legal;
    w_acc_rdata = (w_legal && bus.icb_cmd_read) ? r_mem[w_idx] : '0;
  end

  // Command backpressure depends on registered credit count only
  always_comb begin
    bus.icb_cmd_ready = (r_out < 5'(RSP_DEPTH));
    outstanding       = r_out;
  end

  // Bytewise array write at acceptance; contents survive reset
  always_ff @(posedge clk) begin
    if (w_acc && w_legal && !bus.icb_cmd_read) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.icb_cmd_wmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.icb_cmd_wdata[8*b +: 8];
        end
      end
    end
  end

  // The FIFO write is the last of the LATENCY stages, so only LATENCY-1
  // register stages sit between acceptance and the FIFO.
  if (LATENCY == 1) begin : g_nopipe
    // Accepted command pushes straight into the FIFO
    always_comb begin
      w_push_v     = w_acc;
      w_push_err   = w_acc_err;
      w_push_rdata = w_acc_rdata;
    end
  end else begin : g_pipe
    logic [LATENCY-2:0] r_v;
    logic               r_err   [LATENCY-1];
    logic [31:0]        r_rdata [LATENCY-1];

    // Pipeline valid bits, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= '0;
      end else begin
        r_v[0] <= w_acc;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          r_v[i] <= r_v[i-1];
        end
      end
    end

    // Pipeline payload, qualified by the valid bits
    always_ff @(posedge clk) begin
      r_err[0]   <= w_acc_err;
      r_rdata[0] <= w_acc_rdata;
      for (int unsigned i = 1; i < LATENCY - 1; i++) begin
        r_err[i]   <= r_err[i-1];
        r_rdata[i] <= r_rdata[i-1];
      end
    end

    // Last register stage feeds the FIFO
    always_comb begin
      w_push_v     = r_v[LATENCY-2];
      w_push_err   = r_err[LATENCY-2];
      w_push_rdata = r_rdata[LATENCY-2];
    end
  end

  // FIFO status and pop handshake
  always_comb begin
    w_fifo_ne = (r_cnt != 5'd0);
    w_pop     = w_fifo_ne && bus.icb_rsp_ready;
  end

  // FIFO pointers and occupancy; credits guarantee no overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_v) begin
        r_wp <= f_next(r_wp);
      end
      if (w_pop) begin
        r_rp <= f_next(r_rp);
      end
      case ({w_push_v, w_pop})
        2'b10:   r_cnt <= r_cnt + 5'd1;
        2'b01:   r_cnt <= r_cnt - 5'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_push_v) begin
      r_f_err[r_wp]   <= w_push_err;
      r_f_rdata[r_wp] <= w_push_rdata;
    end
  end

  // Response outputs from the FIFO head, forced to zero when empty
  always_comb begin
    bus.icb_rsp_valid = w_fifo_ne;
    bus.icb_rsp_err   = w_fifo_ne && r_f_err[r_rp];
    bus.icb_rsp_rdata = w_fifo_ne ? r_f_rdata[r_rp] : '0;
  end

  // Credit counter: +1 per accept, -1 per response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      case ({w_acc, w_pop})
        2'b10:   r_out <= r_out + 5'd1;
        2'b01:   r_out <= r_out - 5'd1;
        default: r_out <= r_out;
      endcase
    end
  end

endmodule
